// File: rtl/shift_add_mul_hs.sv
// Iterative shift-and-add multiplier with valid/ready handshakes and runtime signed mode.
// Define MUL_EARLY_EXIT_EN for data-dependent early termination; the default build is constant-time.
module shift_add_mul_hs #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   o,
  output logic                 busy,
  output logic [CNT_W-1:0]     iters
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_mag, b_reg, a_abs, b_abs;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc, acc_nxt, addend, product, o_reg;
  logic [CNT_W-1:0]     cnt, iters_reg;
  logic                 last_iter;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign o         = o_reg;
  assign iters     = iters_reg;

  // The most negative operand maps to 2^(W-1), which is still representable as a W-bit magnitude.
  always_comb begin
    a_abs   = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs   = (is_signed && b[WIDTH-1]) ? -b : b;
    addend  = b_reg[0] ? ({{WIDTH{1'b0}}, a_mag} << cnt) : '0;
    acc_nxt = acc + addend;
    product = neg ? -acc_nxt : acc_nxt;
  end

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (b_reg[WIDTH-1:1] == '0) || (a_mag == '0) ||
                     (cnt == CNT_W'(WIDTH - 1));
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag     <= '0;
      b_reg     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      o_reg     <= '0;
      iters_reg <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_mag <= a_abs;
          b_reg <= b_abs;
          neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            o_reg     <= product;
            iters_reg <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_hs.sv
// Directed self-checking bench for shift_add_mul_hs (WIDTH=8), valid for both build variants.
module tb_shift_add_mul_hs;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   o;
  logic             busy;
  logic [CNT_W-1:0] iters;

  int n_vec = 0;
  int n_err = 0;

  shift_add_mul_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .busy(busy), .iters(iters)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] prod;
    int             it_ee;
  } vec_t;

  vec_t vecs[10] = '{
    '{"u13x11",   8'd13,  8'd11,  1'b0, 16'd143,  4},
    '{"s-3x5",    8'hFD,  8'h05,  1'b1, 16'hFFF1, 3},
    '{"s80x80",   8'h80,  8'h80,  1'b1, 16'h4000, 8},
    '{"uffxff",   8'hFF,  8'hFF,  1'b0, 16'hFE01, 8},
    '{"u0x77",    8'd0,   8'd77,  1'b0, 16'h0000, 1},
    '{"u9x1",     8'd9,   8'd1,   1'b0, 16'd9,    1},
    '{"u3x10",    8'd3,   8'h10,  1'b0, 16'h0030, 5},
    '{"s0xm1",    8'h00,  8'hFF,  1'b1, 16'h0000, 1},
    '{"s7fx80",   8'h7F,  8'h80,  1'b1, 16'hC080, 8},
    '{"sm1xm1",   8'hFF,  8'hFF,  1'b1, 16'h0001, 1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_iters(input int it_ee);
`ifdef MUL_EARLY_EXIT_EN
    return it_ee;
`else
    return W;
`endif
  endfunction

  // Starts and ends at a falling edge; ends just after the accept edge.
  task automatic accept(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a = av; b = bv; is_signed = sv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 'x; b = 'x; is_signed = 1'bx;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, ".timeout"}, out_valid, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    accept(v.tag, v.a, v.b, v.s);
    wait_done(v.tag, lat);
    check({v.tag, ".latency"}, lat, exp_iters(v.it_ee));
    check({v.tag, ".o"}, o, v.prod);
    check({v.tag, ".iters"}, iters, exp_iters(v.it_ee));
    check({v.tag, ".busy"}, busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check({v.tag, ".one_cycle"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0]   o_hold;
    logic [CNT_W-1:0] it_hold;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.o", o, 16'h0);
    check("rst.iters", iters, 0);
    check("rst.busy", busy, 1'b0);
    check("rst.in_ready", in_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result must hold and extra in_valid pulses must be ignored.
    out_ready = 1'b0;
    accept("bp", 8'd13, 8'd11, 1'b0);
    wait_done("bp", lat);
    o_hold = o; it_hold = iters;
    check("bp.o", o_hold, 16'd143);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 8'd2; b = 8'd3; is_signed = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp.hold_o", o, o_hold);
      check("bp.hold_iters", iters, it_hold);
      check("bp.in_ready", in_ready, 1'b0);
      check("bp.out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.release_valid", out_valid, 1'b0);
    check("bp.release_ready", in_ready, 1'b1);
    check("bp.release_busy", busy, 1'b0);

    // Reset in the middle of a run, then a clean operation.
    accept("abort", 8'd200, 8'd200, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort.busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.o", o, 16'h0);
    check("abort.busy", busy, 1'b0);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) check("abort.stale_valid", out_valid, 1'b0);
    end
    run_vec('{"after_abort", 8'd6, 8'd7, 1'b0, 16'd42, 3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
